if_fetch_unit: RTL and testbench

//  Instruction-fetch front end: owns the PC, issues requests to instruction memory via a
//  req/ready handshake, and drives pc_out/instruction_out into the IF/ID stage register.

---
 rtl/if_pkg.sv | 29 ++
 rtl/if_hold_buffer.sv | 58 +++++
 rtl/if_fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t     : fetch FSM state encoding (IDLE, FETCH, HOLD, DRAIN)
//   NOP_INSTR         : instruction word offered when nothing valid is presented
//   DEFAULT_RESET_PC  : default PC loaded on reset
//   DEFAULT_PC_INC    : default byte increment per sequential fetch
//   next_seq_pc()     : sequential PC step, wraps modulo 2^32
// -----------------------------------------------------------------------------
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_INC   = 32'h0000_0004;

  // Plain 32-bit add: 0xFFFF_FFFC + 4 wraps to 0x0 by construction.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc,
                                              input logic [31:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// -----------------------------------------------------------------------------
// if_hold_buffer
// One-entry {pc, instr} register that parks an instruction returned by memory
// while the IF/ID register is frozen. Clear has priority over load.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   load            : capture pc_in/instr_in
//   clear           : zero the entry (flush)
//   pc_in, instr_in : PC of the fetched instruction and its word
//   pc_out,instr_out: stored entry
// -----------------------------------------------------------------------------
module if_hold_buffer
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Next-value selection for the entry: clear, load or keep.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      pc_d    = 32'h0000_0000;
      instr_d = NOP_INSTR;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
    end else begin
      pc_d    = pc_q;
      instr_d = instr_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end. Owns the PC, requests instruction words over a
// req/ready handshake and offers them to the IF/ID register, honouring the same
// freeze (hold) and branch_taken (flush, wins over freeze) as that register.
// One instruction per cycle on zero-wait memory.
// Ports:
//   clk, rst                 : clock (rising edge), async active-high reset
//   freeze                   : IF/ID hold; offered instruction not consumed
//   branch_taken, branch_addr: redirect/flush and its target
//   imem_req, imem_addr      : request, held with stable address until ready
//   imem_ready, imem_rdata   : response strobe and instruction word
//   valid_out                : pc_out/instruction_out carry a real instruction
//   pc_out, instruction_out  : PC+PC_INC and word of the offered instruction
//   fetch_count              : accepted-instruction counter
// Configuration macro: IF_FETCH_COUNT_EN enables fetch_count; otherwise it is
// tied to zero and the counter is not built.
// -----------------------------------------------------------------------------
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_INC   = DEFAULT_PC_INC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  // Address of a request abandoned by a redirect; presented while draining so
  // the memory sees a stable address until it answers.
  logic [31:0]  req_addr_q, req_addr_d;
  logic         hold_load, hold_clear;
  logic [31:0]  hold_pc, hold_instr;

  if_hold_buffer u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .pc_in     (pc_q),
    .instr_in  (imem_rdata),
    .pc_out    (hold_pc),
    .instr_out (hold_instr)
  );

  // Output decode per state; FETCH bypasses the memory response straight out.
  always_comb begin
    imem_req        = 1'b0;
    valid_out       = 1'b0;
    pc_out          = 32'h0000_0000;
    instruction_out = NOP_INSTR;
    case (state_q)
      IDLE: begin
        imem_req = 1'b0;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          valid_out       = 1'b1;
          pc_out          = next_seq_pc(pc_q, PC_INC);
          instruction_out = imem_rdata;
        end else begin
          valid_out = 1'b0;
        end
      end
      HOLD: begin
        valid_out       = 1'b1;
        pc_out          = next_seq_pc(hold_pc, PC_INC);
        instruction_out = hold_instr;
      end
      DRAIN: begin
        imem_req = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign imem_addr = (state_q == DRAIN) ? req_addr_q : pc_q;

  // Next-state, PC and hold-buffer control. A redirect outranks freeze.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          hold_clear = 1'b1;
          if (!imem_ready) begin
            // Memory still owes us a word for pc_q; swallow it in DRAIN.
            state_d    = DRAIN;
            req_addr_d = pc_q;
          end else begin
            state_d = FETCH;
          end
        end else if (imem_ready) begin
          if (freeze) begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end else begin
            pc_d    = next_seq_pc(pc_q, PC_INC);
            state_d = FETCH;
          end
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          hold_clear = 1'b1;
          state_d    = FETCH;
        end else if (freeze) begin
          state_d = HOLD;
        end else begin
          // pc_q still addresses the held instruction.
          pc_d    = next_seq_pc(pc_q, PC_INC);
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          pc_d       = branch_addr;
          hold_clear = 1'b1;
          state_d    = imem_ready ? FETCH : DRAIN;
        end else if (imem_ready) begin
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, PC and drain-address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic        accept;
  logic [31:0] fetch_count_q, fetch_count_d;

  assign accept = valid_out & ~freeze & ~branch_taken;

  // Accepted-instruction counter, wraps modulo 2^32.
  always_comb begin
    if (accept) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed, table-driven bench for if_fetch_unit. Each table row holds the
// inputs applied for one cycle and the outputs expected in that cycle (before
// the next rising edge). Hand-written sequences follow for async reset
// mid-drain and PC wrap-around.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .fetch_count     (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fr;
    logic        br;
    logic        rdy;
    logic [31:0] baddr;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fr, input logic br, input logic rdy,
                     input logic [31:0] baddr, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic [31:0] e_cnt);
    vec_t v;
    v.fr = fr; v.br = br; v.rdy = rdy; v.baddr = baddr; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef IF_FETCH_COUNT_EN
    return c;
`else
    return (c & 32'h0000_0000);
`endif
  endfunction

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc,
                         input logic [31:0] e_instr, input logic [31:0] e_cnt);
    chk({tag, " req"},   {31'd0, imem_req},  {31'd0, e_req});
    chk({tag, " addr"},  imem_addr,          e_addr);
    chk({tag, " valid"}, {31'd0, valid_out}, {31'd0, e_valid});
    chk({tag, " pc"},    pc_out,             e_pc);
    chk({tag, " instr"}, instruction_out,    e_instr);
    chk({tag, " count"}, fetch_count,        cnt_exp(e_cnt));
  endtask

  task automatic drive(input logic fr, input logic br, input logic rdy,
                       input logic [31:0] baddr, input logic [31:0] rdata);
    freeze = fr; branch_taken = br; imem_ready = rdy;
    branch_addr = baddr; imem_rdata = rdata;
  endtask

  initial begin
    //  fr  br  rdy baddr          rdata          req addr           vld pc             instr          cnt
    add(0,  0,  1,  32'h0,         32'h0,         0,  32'h0,         0,  32'h0,         32'h0,         32'd0); // IDLE
    add(0,  0,  1,  32'h0,         32'hA000_0000, 1,  32'h0,         1,  32'h4,         32'hA000_0000, 32'd0);
    add(0,  0,  1,  32'h0,         32'hA000_0004, 1,  32'h4,         1,  32'h8,         32'hA000_0004, 32'd1);
    add(0,  0,  0,  32'h0,         32'hDEAD_BEEF, 1,  32'h8,         0,  32'h0,         32'h0,         32'd2); // wait state
    add(0,  0,  0,  32'h0,         32'hDEAD_BEEF, 1,  32'h8,         0,  32'h0,         32'h0,         32'd2);
    add(0,  0,  0,  32'h0,         32'hDEAD_BEEF, 1,  32'h8,         0,  32'h0,         32'h0,         32'd2);
    add(0,  0,  1,  32'h0,         32'hA000_0008, 1,  32'h8,         1,  32'hC,         32'hA000_0008, 32'd2);
    add(1,  0,  1,  32'h0,         32'hA000_000C, 1,  32'hC,         1,  32'h10,        32'hA000_000C, 32'd3); // -> HOLD
    add(1,  0,  0,  32'h0,         32'hDEAD_BEEF, 0,  32'hC,         1,  32'h10,        32'hA000_000C, 32'd3);
    add(1,  0,  1,  32'h0,         32'hDEAD_BEEF, 0,  32'hC,         1,  32'h10,        32'hA000_000C, 32'd3);
    add(1,  0,  1,  32'h0,         32'hDEAD_BEEF, 0,  32'hC,         1,  32'h10,        32'hA000_000C, 32'd3);
    add(0,  0,  1,  32'h0,         32'hDEAD_BEEF, 0,  32'hC,         1,  32'h10,        32'hA000_000C, 32'd3); // release
    add(0,  0,  1,  32'h0,         32'hA000_0010, 1,  32'h10,        1,  32'h14,        32'hA000_0010, 32'd4);
    add(1,  1,  1,  32'h100,       32'hA000_0014, 1,  32'h14,        1,  32'h18,        32'hA000_0014, 32'd5); // branch+freeze
    add(0,  0,  1,  32'h0,         32'hA000_0100, 1,  32'h100,       1,  32'h104,       32'hA000_0100, 32'd5);
    add(1,  0,  1,  32'h0,         32'hA000_0104, 1,  32'h104,       1,  32'h108,       32'hA000_0104, 32'd6); // -> HOLD
    add(1,  1,  0,  32'h200,       32'hDEAD_BEEF, 0,  32'h104,       1,  32'h108,       32'hA000_0104, 32'd6); // branch in HOLD
    add(0,  0,  1,  32'h0,         32'hA000_0200, 1,  32'h200,       1,  32'h204,       32'hA000_0200, 32'd6);
    add(0,  1,  0,  32'h300,       32'hDEAD_BEEF, 1,  32'h204,       0,  32'h0,         32'h0,         32'd7); // -> DRAIN
    add(0,  0,  0,  32'h0,         32'h5555_5555, 1,  32'h204,       0,  32'h0,         32'h0,         32'd7);
    add(0,  0,  1,  32'h0,         32'h5555_5555, 1,  32'h204,       0,  32'h0,         32'h0,         32'd7); // stale dropped
    add(0,  0,  1,  32'h0,         32'hA000_0300, 1,  32'h300,       1,  32'h304,       32'hA000_0300, 32'd7);
    add(0,  1,  0,  32'h400,       32'hDEAD_BEEF, 1,  32'h304,       0,  32'h0,         32'h0,         32'd8); // -> DRAIN
    add(0,  1,  0,  32'h500,       32'hDEAD_BEEF, 1,  32'h304,       0,  32'h0,         32'h0,         32'd8); // retarget
    add(0,  0,  1,  32'h0,         32'h6666_6666, 1,  32'h304,       0,  32'h0,         32'h0,         32'd8);
    add(0,  0,  1,  32'h0,         32'hA000_0500, 1,  32'h500,       1,  32'h504,       32'hA000_0500, 32'd8);

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    drive(0, 0, 1, 32'h0, 32'hFFFF_FFFF);
    #1;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fr, vecs[i].br, vecs[i].rdy, vecs[i].baddr, vecs[i].rdata);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_cnt);
      @(negedge clk);
    end

    // Async reset in the middle of a drain
    drive(0, 1, 0, 32'h600, 32'hDEAD_BEEF);
    #1;
    chk_all("pre_drain", 1'b1, 32'h504, 1'b0, 32'h0, 32'h0, 32'd9);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 32'hDEAD_BEEF);
    #1;
    chk_all("drain", 1'b1, 32'h504, 1'b0, 32'h0, 32'h0, 32'd9);
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 1, 32'h0, 32'h0000_0011);
    #1;
    chk_all("restart_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    #1;
    chk_all("restart_fetch", 1'b1, 32'h0, 1'b1, 32'h4, 32'h0000_0011, 32'd0);
    @(negedge clk);

    // PC wrap 0xFFFF_FFFC -> 0x0
    drive(0, 1, 1, 32'hFFFF_FFFC, 32'h0000_0033);
    #1;
    chk_all("wrap_branch", 1'b1, 32'h4, 1'b1, 32'h8, 32'h0000_0033, 32'd1);
    @(negedge clk);
    drive(0, 0, 1, 32'h0, 32'h0000_0022);
    #1;
    chk_all("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0000_0022, 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 32'h0);
    #1;
    chk_all("wrap_zero", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'd2);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
